// File: rtl/hazard_forwarding_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit: operand-mux selects,
// FSM states and the event counter width.
package hazard_forwarding_unit_pkg;
  localparam int CNT_W   = 8;
  localparam int NUM_OPS = 3;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [3:0] rd;
    logic       en;
  } dst_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: EX > MEM > WB priority, R15 never forwarded,
// and an EX hit on a load is reported as load-use instead of forwarded.
module hazard_fwd_sel
  import hazard_forwarding_unit_pkg::*;
(
  input  logic [3:0] i_src,
  input  logic       i_use,
  input  dst_t       i_ex,
  input  dst_t       i_mem,
  input  dst_t       i_wb,
  input  logic       i_ex_load,
  output logic [1:0] o_sel,
  output logic       o_load_use
);
  logic w_live, w_ex_hit, w_mem_hit, w_wb_hit;

  assign w_live    = i_use && (i_src != REG_PC);
  assign w_ex_hit  = w_live && i_ex.en  && (i_ex.rd  == i_src);
  assign w_mem_hit = w_live && i_mem.en && (i_mem.rd == i_src);
  assign w_wb_hit  = w_live && i_wb.en  && (i_wb.rd  == i_src);

  always_comb begin
    o_sel = SEL_RF;
    if (w_ex_hit && !i_ex_load) o_sel = SEL_EX;
    else if (w_mem_hit)         o_sel = SEL_MEM;
    else if (w_wb_hit)          o_sel = SEL_WB;
  end

  assign o_load_use = w_ex_hit && i_ex_load;
endmodule

// File: rtl/hazard_forwarding_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use stall and
// taken-branch flush control, with saturating stall/flush event counters.
module hazard_forwarding_unit
  import hazard_forwarding_unit_pkg::*;
(
  input  logic             Clk,
  input  logic             Clr,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic [3:0]       ID_Rd,
  input  logic             ID_use_Rn,
  input  logic             ID_use_Rm,
  input  logic             ID_use_Rd,
  input  logic [3:0]       EX_RD,
  input  logic [3:0]       MEM_RD,
  input  logic [3:0]       WB_RD,
  input  logic             EX_RF_enable,
  input  logic             MEM_RF_enable,
  input  logic             WB_RF_enable,
  input  logic             EX_load_instr,
  input  logic             branch_taken,
  output logic [1:0]       SelPA,
  output logic [1:0]       SelPB,
  output logic [1:0]       SelPD,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             NOP_E,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [NUM_OPS-1:0][3:0] w_src;
  logic [NUM_OPS-1:0]      w_use;
  logic [NUM_OPS-1:0][1:0] w_sel;
  logic [NUM_OPS-1:0]      w_lu;
  dst_t                    w_ex, w_mem, w_wb;
  logic                    w_load_use, w_branch;
  logic [1:0]              r_state, w_next;
  logic [CNT_W-1:0]        r_stall_cnt, r_flush_cnt;

  // Operand order: 0 = Rn (PA), 1 = Rm (PB), 2 = Rd store data (PD)
  assign w_src = {ID_Rd, ID_Rm, ID_Rn};
  assign w_use = {ID_use_Rd, ID_use_Rm, ID_use_Rn};
  assign w_ex  = '{rd: EX_RD,  en: EX_RF_enable};
  assign w_mem = '{rd: MEM_RD, en: MEM_RF_enable};
  assign w_wb  = '{rd: WB_RD,  en: WB_RF_enable};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    hazard_fwd_sel u_sel (
      .i_src      (w_src[g]),
      .i_use      (w_use[g]),
      .i_ex       (w_ex),
      .i_mem      (w_mem),
      .i_wb       (w_wb),
      .i_ex_load  (EX_load_instr),
      .o_sel      (w_sel[g]),
      .o_load_use (w_lu[g])
    );
  end

  // Held in reset, every control output falls back to its idle value.
  assign SelPA      = Clr ? w_sel[0] : SEL_RF;
  assign SelPB      = Clr ? w_sel[1] : SEL_RF;
  assign SelPD      = Clr ? w_sel[2] : SEL_RF;
  assign w_load_use = Clr && (|w_lu);
  assign w_branch   = Clr && branch_taken;

  always_comb begin
    PC_LE       = 1'b1;
    IF_ID_LE    = 1'b1;
    NOP_E       = 1'b0;
    IF_ID_flush = 1'b0;
    w_next      = ST_RUN;
    case (r_state)
      ST_RUN: begin
        if (w_branch) begin
          IF_ID_flush = 1'b1;
          w_next      = ST_FLUSH;
        end else if (w_load_use) begin
          PC_LE    = 1'b0;
          IF_ID_LE = 1'b0;
          NOP_E    = 1'b1;
          w_next   = ST_STALL;
        end
      end
      ST_STALL: w_next = ST_RUN;
      ST_FLUSH: begin
        NOP_E  = 1'b1;
        w_next = ST_RUN;
      end
      default: w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_RUN && w_next == ST_STALL) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (r_state == ST_RUN && w_next == ST_FLUSH) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed + short random bench for hazard_forwarding_unit with a reference
// model feeding an expectation queue.
module tb_hazard_forwarding_unit;
  logic       Clk = 1'b0;
  logic       Clr;
  logic [3:0] ID_Rn, ID_Rm, ID_Rd, EX_RD, MEM_RD, WB_RD;
  logic       ID_use_Rn, ID_use_Rm, ID_use_Rd;
  logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable;
  logic       EX_load_instr, branch_taken;
  logic [1:0] SelPA, SelPB, SelPD;
  logic       PC_LE, IF_ID_LE, NOP_E, IF_ID_flush;
  logic [7:0] stall_cnt, flush_cnt;

  typedef struct {
    logic [1:0] pa, pb, pd;
    logic       pc, ifid, nop, fl;
    logic [7:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_state = 0;
  logic [7:0] m_stall = 0, m_flush = 0;
  logic m_lu, m_br;

  always #5 Clk = ~Clk;

  hazard_forwarding_unit dut (
    .Clk(Clk), .Clr(Clr),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
    .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
    .EX_RD(EX_RD), .MEM_RD(MEM_RD), .WB_RD(WB_RD),
    .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
    .EX_load_instr(EX_load_instr), .branch_taken(branch_taken),
    .SelPA(SelPA), .SelPB(SelPB), .SelPD(SelPD),
    .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .NOP_E(NOP_E), .IF_ID_flush(IF_ID_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [1:0] m_sel(input logic [3:0] s, input logic u);
    logic [1:0] r;
    r = 2'd0;
    if (u && s != 4'd15) begin
      if (WB_RF_enable && WB_RD == s) r = 2'd3;
      if (MEM_RF_enable && MEM_RD == s) r = 2'd2;
      if (EX_RF_enable && EX_RD == s && !EX_load_instr) r = 2'd1;
    end
    return r;
  endfunction

  function automatic logic m_hit_ex(input logic [3:0] s, input logic u);
    return u && s != 4'd15 && s == EX_RD;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    {ID_Rn, ID_Rm, ID_Rd, EX_RD, MEM_RD, WB_RD} = '0;
    {ID_use_Rn, ID_use_Rm, ID_use_Rd} = '0;
    {EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr, branch_taken} = '0;
  endtask

  // Predict outputs for the current inputs, queue them, then compare.
  task automatic apply();
    exp_t e, o;
    if (!Clr) begin m_state = 0; m_stall = 0; m_flush = 0; end
    m_lu = Clr && EX_load_instr && EX_RF_enable &&
           (m_hit_ex(ID_Rn, ID_use_Rn) || m_hit_ex(ID_Rm, ID_use_Rm) || m_hit_ex(ID_Rd, ID_use_Rd));
    m_br = Clr && branch_taken;
    e.pa = Clr ? m_sel(ID_Rn, ID_use_Rn) : 2'd0;
    e.pb = Clr ? m_sel(ID_Rm, ID_use_Rm) : 2'd0;
    e.pd = Clr ? m_sel(ID_Rd, ID_use_Rd) : 2'd0;
    e.pc = 1'b1; e.ifid = 1'b1; e.nop = 1'b0; e.fl = 1'b0;
    if (m_state == 0 && m_br) e.fl = 1'b1;
    else if (m_state == 0 && m_lu) begin e.pc = 1'b0; e.ifid = 1'b0; e.nop = 1'b1; end
    if (m_state == 2) e.nop = 1'b1;
    e.sc = m_stall; e.fc = m_flush;
    q.push_back(e);
    #1;
    o = q.pop_front();
    cmp("SelPA", SelPA, o.pa);
    cmp("SelPB", SelPB, o.pb);
    cmp("SelPD", SelPD, o.pd);
    cmp("PC_LE", PC_LE, o.pc);
    cmp("IF_ID_LE", IF_ID_LE, o.ifid);
    cmp("NOP_E", NOP_E, o.nop);
    cmp("IF_ID_flush", IF_ID_flush, o.fl);
    cmp("stall_cnt", stall_cnt, o.sc);
    cmp("flush_cnt", flush_cnt, o.fc);
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Clr) begin
      case (m_state)
        0: if (m_br) begin m_state = 2; if (m_flush != 8'hFF) m_flush++; end
           else if (m_lu) begin m_state = 1; if (m_stall != 8'hFF) m_stall++; end
        default: m_state = 0;
      endcase
    end
    @(negedge Clk);
  endtask

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  task automatic set_load_use2();
    clear_in();
    ID_Rn = 4'd2; ID_use_Rn = 1'b1;
    EX_RD = 4'd2; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
  endtask

  initial begin
    clear_in();
    Clr = 1'b0;
    @(negedge Clk);
    // Reset with a hazard present on the inputs
    set_load_use2(); branch_taken = 1'b1;
    apply();
    cmp("rst_PC_LE", PC_LE, 8'd1);
    cmp("rst_SelPA", SelPA, 8'd0);
    tick();
    Clr = 1'b1;

    clear_in();
    ID_Rn = 4'd3; ID_use_Rn = 1'b1; EX_RD = 4'd3; EX_RF_enable = 1'b1;
    apply();
    cmp("ex_fwd_SelPA", SelPA, 8'd1);
    cmp("ex_fwd_nostall", PC_LE, 8'd1);
    tick();

    clear_in();
    ID_Rm = 4'd5; ID_use_Rm = 1'b1;
    MEM_RD = 4'd5; MEM_RF_enable = 1'b1; WB_RD = 4'd5; WB_RF_enable = 1'b1;
    apply();
    cmp("mem_over_wb_SelPB", SelPB, 8'd2);
    tick();

    clear_in();
    ID_Rd = 4'd7; ID_use_Rd = 1'b1; EX_RD = 4'd7; WB_RD = 4'd7; WB_RF_enable = 1'b1;
    apply();
    cmp("wb_fwd_SelPD", SelPD, 8'd3);
    tick();

    clear_in();
    ID_Rd = 4'd15; ID_use_Rd = 1'b1; EX_RD = 4'd15; EX_RF_enable = 1'b1;
    apply();
    cmp("r15_SelPD", SelPD, 8'd0);
    tick();

    set_load_use2();
    apply();
    cmp("lu_PC_LE", PC_LE, 8'd0);
    cmp("lu_NOP_E", NOP_E, 8'd1);
    tick();
    clear_in();
    ID_Rn = 4'd2; ID_use_Rn = 1'b1; MEM_RD = 4'd2; MEM_RF_enable = 1'b1;
    apply();
    cmp("stall_SelPA", SelPA, 8'd2);
    cmp("stall_cnt1", stall_cnt, 8'd1);
    cmp("stall_PC_LE", PC_LE, 8'd1);
    tick();

    // Branch wins over load-use; a branch seen while flushing is ignored
    set_load_use2(); branch_taken = 1'b1;
    apply();
    cmp("br_flush", IF_ID_flush, 8'd1);
    cmp("br_PC_LE", PC_LE, 8'd1);
    tick();
    clear_in(); branch_taken = 1'b1;
    apply();
    cmp("flush_NOP_E", NOP_E, 8'd1);
    cmp("flush_cnt1", flush_cnt, 8'd1);
    cmp("flush_stall_cnt", stall_cnt, 8'd1);
    cmp("flush_no_reflush", IF_ID_flush, 8'd0);
    tick();
    clear_in();
    apply();
    cmp("flush_cnt_hold", flush_cnt, 8'd1);
    tick();

    // Load-use held across the STALL cycle must not re-stall there
    set_load_use2(); apply(); tick();
    apply();
    cmp("no_restall_PC_LE", PC_LE, 8'd1);
    tick();

    for (int i = 0; i < 40; i++) begin
      ID_Rn = rnd_reg(); ID_Rm = rnd_reg(); ID_Rd = rnd_reg();
      EX_RD = rnd_reg(); MEM_RD = rnd_reg(); WB_RD = rnd_reg();
      {ID_use_Rn, ID_use_Rm, ID_use_Rd} = 3'($urandom);
      {EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr} = 4'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      apply(); tick();
    end

    for (int i = 0; i < 300; i++) begin
      set_load_use2(); apply(); tick();
      clear_in(); apply(); tick();
    end
    cmp("stall_sat", stall_cnt, 8'd255);

    set_load_use2(); apply(); tick();
    #2 Clr = 1'b0;
    apply();
    cmp("midstall_rst_stall_cnt", stall_cnt, 8'd0);
    cmp("midstall_rst_flush_cnt", flush_cnt, 8'd0);
    cmp("midstall_rst_NOP_E", NOP_E, 8'd0);
    @(negedge Clk);
    Clr = 1'b1;
    apply();
    cmp("post_rst_stall", PC_LE, 8'd0);
    tick();
    apply();
    cmp("post_rst_stall_cnt", stall_cnt, 8'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
